// File: rtl/spi_accel_slave_if.sv
// SPI pin bundle between the byte-level SPI master and the emulated
// 3-axis sensor; idle levels are sclk=1, cs_n=1.
interface spi_accel_slave_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_accel_slave.sv
// SPI mode-3 responder emulating a 3-axis sensor register map: address decode,
// control-register writes, coherent X/Y/Z reads from a shadow copy, data-ready irq.
module spi_accel_slave #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_accel_slave_if.slave   spi,
  input  logic               sample_valid,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  input  logic signed [15:0] z_in,
  output logic               interrupt,
  output logic [7:0]         ctrl_reg1,
  output logic [7:0]         ctrl_reg3,
  output logic [7:0]         ctrl_reg4
);

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_p0, cs_p0, mosi_p0;
  logic sclk_d, cs_d;
  logic sclk_rise_p1, sclk_fall_p1, cs_rise_p1, cs_fall_p1;
  logic mosi_p1;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sreg;
  logic [7:0] tx_sreg;
  logic [5:0] addr;
  logic       inc;
  logic       armed;
  logic       miso_oe_r;

  logic signed [15:0] x_live, y_live, z_live;
  logic signed [15:0] x_sh, y_sh, z_sh;
  logic               zyxda, zyxda_sh;
  logic               fresh;

  logic [7:0] byte_in;
  logic [5:0] load_addr;
  logic [7:0] rd_data;

  // Stage p0: input synchronisers (free-running so they track the pins through reset)
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi.cs_n};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
    sclk_d    <= sclk_p0;
    cs_d      <= cs_p0;
    mosi_p1   <= mosi_p0;
  end

  assign sclk_p0 = sclk_sync[SYNC_STAGES-1];
  assign cs_p0   = cs_sync[SYNC_STAGES-1];
  assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

  // Stage p1: registered edge strobes; all protocol actions key off these
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_rise_p1 <= 1'b0;
      sclk_fall_p1 <= 1'b0;
      cs_rise_p1   <= 1'b0;
      cs_fall_p1   <= 1'b0;
    end else begin
      sclk_rise_p1 <= sclk_p0 & ~sclk_d;
      sclk_fall_p1 <= ~sclk_p0 & sclk_d;
      cs_rise_p1   <= cs_p0 & ~cs_d;
      cs_fall_p1   <= ~cs_p0 & cs_d;
    end
  end

  assign byte_in = {rx_sreg, mosi_p1};

  always_comb begin
    load_addr = addr;
    if (state == ADDR)
      load_addr = byte_in[5:0];
    else if (inc)
      load_addr = addr + 6'd1;
  end

  // Read side sees the shadow snapshot so multi-byte axis reads stay coherent
  always_comb begin
    rd_data = 8'h00;
    case (load_addr)
      6'h0F:   rd_data = WHO_AM_I_VAL;
      6'h20:   rd_data = ctrl_reg1;
      6'h22:   rd_data = ctrl_reg3;
      6'h23:   rd_data = ctrl_reg4;
      6'h27:   rd_data = {4'b0000, zyxda_sh, 3'b000};
      6'h28:   rd_data = x_sh[7:0];
      6'h29:   rd_data = x_sh[15:8];
      6'h2A:   rd_data = y_sh[7:0];
      6'h2B:   rd_data = y_sh[15:8];
      6'h2C:   rd_data = z_sh[7:0];
      6'h2D:   rd_data = z_sh[15:8];
      default: rd_data = 8'h00;
    endcase
  end

  // Stage p2: protocol FSM, register file and sample capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      tx_sreg   <= 8'h00;
      addr      <= 6'd0;
      inc       <= 1'b0;
      armed     <= 1'b0;
      miso_oe_r <= 1'b0;
      ctrl_reg1 <= 8'h00;
      ctrl_reg3 <= 8'h00;
      ctrl_reg4 <= 8'h00;
      x_live    <= '0;
      y_live    <= '0;
      z_live    <= '0;
      x_sh      <= '0;
      y_sh      <= '0;
      z_sh      <= '0;
      zyxda     <= 1'b0;
      zyxda_sh  <= 1'b0;
      fresh     <= 1'b0;
    end else begin
      miso_oe_r <= ~cs_p0;
      if (cs_p0)
        armed <= 1'b1;

      if (cs_rise_p1) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        tx_sreg <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall_p1 && armed) begin
              state    <= ADDR;
              bit_cnt  <= 3'd0;
              tx_sreg  <= 8'h00;
              x_sh     <= x_live;
              y_sh     <= y_live;
              z_sh     <= z_live;
              zyxda_sh <= zyxda;
              fresh    <= 1'b0;
            end
          end
          default: begin
            if (sclk_rise_p1) begin
              rx_sreg <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == WRITE) begin
                  case (addr)
                    6'h20:   ctrl_reg1 <= byte_in;
                    6'h22:   ctrl_reg3 <= byte_in;
                    6'h23:   ctrl_reg4 <= byte_in;
                    default: ;
                  endcase
                  if (inc)
                    addr <= addr + 6'd1;
                end else if (state == ADDR && !byte_in[7]) begin
                  state <= WRITE;
                  inc   <= byte_in[6];
                  addr  <= byte_in[5:0];
                end else begin
                  if (state == ADDR)
                    inc <= byte_in[6];
                  state   <= READ;
                  addr    <= load_addr;
                  tx_sreg <= rd_data;
                  // Only clear if the flag refers to data already snapshotted
                  if (load_addr == 6'h2D && !fresh)
                    zyxda <= 1'b0;
                end
              end
            end else if (sclk_fall_p1 && bit_cnt != 3'd0) begin
              tx_sreg <= {tx_sreg[6:0], 1'b0};
            end
          end
        endcase
      end

      // Placed last so a new sample wins over a same-cycle clear
      if (sample_valid && ctrl_reg1[3]) begin
        x_live <= x_in;
        y_live <= y_in;
        z_live <= z_in;
        zyxda  <= 1'b1;
        fresh  <= 1'b1;
      end
    end
  end

  assign spi.miso    = tx_sreg[7];
  assign spi.miso_oe = miso_oe_r;
  assign interrupt   = zyxda & ctrl_reg3[3];

endmodule

// File: tb/tb_spi_accel_slave.sv
// Self-checking bench for spi_accel_slave: SPI master tasks plus a
// transaction-level register-map model of the sensor.
module tb_spi_accel_slave;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic sample_valid;
  logic signed [15:0] x_in, y_in, z_in;
  logic interrupt;
  logic [7:0] ctrl_reg1, ctrl_reg3, ctrl_reg4;

  spi_accel_slave_if spi ();

  spi_accel_slave #(.WHO_AM_I_VAL(8'hD3), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .interrupt    (interrupt),
    .ctrl_reg1    (ctrl_reg1),
    .ctrl_reg3    (ctrl_reg3),
    .ctrl_reg4    (ctrl_reg4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  m_c1, m_c3, m_c4;
  logic [15:0] m_x, m_y, m_z;
  logic        m_zyxda, m_fresh;
  logic [7:0]  s_map [64];
  logic [7:0]  tx_buf [8];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_c1 = 8'h00; m_c3 = 8'h00; m_c4 = 8'h00;
    m_x = 16'h0; m_y = 16'h0; m_z = 16'h0;
    m_zyxda = 1'b0; m_fresh = 1'b0;
  endtask

  task automatic pulse_sample(input logic [15:0] ix, input logic [15:0] iy, input logic [15:0] iz);
    x_in = ix; y_in = iy; z_in = iz;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
    if (m_c1[3]) begin
      m_x = ix; m_y = iy; m_z = iz;
      m_zyxda = 1'b1;
      m_fresh = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int j = 0; j < nbits; j++) begin
      spi.sclk = 1'b0;
      spi.mosi = b[7-j];
      wait_clk(HALF);
      r[7-j] = spi.miso;
      spi.sclk = 1'b1;
      wait_clk(HALF);
    end
  endtask

  // One chip-select frame of tx_buf[0..nbytes-1]; last byte may be cut short.
  task automatic spi_xfer(input int nbytes, input int last_bits, input int inj_after,
                          input logic [15:0] ix, input logic [15:0] iy, input logic [15:0] iz);
    logic       rd, inc;
    logic [5:0] cur;
    logic [7:0] pend, got;
    int         nb;
    spi.cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 64; i++) s_map[i] = 8'h00;
    s_map[6'h0F] = 8'hD3;
    s_map[6'h20] = m_c1;
    s_map[6'h22] = m_c3;
    s_map[6'h23] = m_c4;
    s_map[6'h27] = m_zyxda ? 8'h08 : 8'h00;
    {s_map[6'h29], s_map[6'h28]} = m_x;
    {s_map[6'h2B], s_map[6'h2A]} = m_y;
    {s_map[6'h2D], s_map[6'h2C]} = m_z;
    m_fresh = 1'b0;
    rd = tx_buf[0][7];
    inc = tx_buf[0][6];
    cur = tx_buf[0][5:0];
    pend = 8'h00;
    for (int k = 0; k < nbytes; k++) begin
      nb = (k == nbytes - 1 && last_bits > 0) ? last_bits : 8;
      send_bits(tx_buf[k], nb, got);
      if (k == 0) check("miso_oe_active", {15'd0, spi.miso_oe}, 16'd1);
      if (nb == 8) begin
        if (k == 0)
          check("miso_addr_byte", {8'd0, got}, 16'd0);
        else if (!rd)
          check("miso_write_byte", {8'd0, got}, 16'd0);
        else
          check("read_byte", {8'd0, got}, {8'd0, pend});
        if (rd) begin
          if (k > 0 && inc) cur = cur + 6'd1;
          pend = s_map[cur];
          if (cur == 6'h2D && !m_fresh) m_zyxda = 1'b0;
        end else if (k > 0) begin
          case (cur)
            6'h20: m_c1 = tx_buf[k];
            6'h22: m_c3 = tx_buf[k];
            6'h23: m_c4 = tx_buf[k];
            default: ;
          endcase
          if (inc) cur = cur + 6'd1;
        end
      end
      if (k == inj_after) pulse_sample(ix, iy, iz);
    end
    wait_clk(HALF);
    spi.cs_n = 1'b1;
    wait_clk(8);
    check("miso_oe_idle", {15'd0, spi.miso_oe}, 16'd0);
    check("interrupt", {15'd0, interrupt}, {15'd0, m_zyxda & m_c3[3]});
    check("ctrl_reg1", {8'd0, ctrl_reg1}, {8'd0, m_c1});
    check("ctrl_reg3", {8'd0, ctrl_reg3}, {8'd0, m_c3});
    check("ctrl_reg4", {8'd0, ctrl_reg4}, {8'd0, m_c4});
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    tx_buf[0] = {2'b00, a};
    tx_buf[1] = d;
    spi_xfer(2, 0, -1, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic rd_burst(input logic [5:0] a, input logic inc, input int n, input int inj_after,
                          input logic [15:0] ix, input logic [15:0] iy, input logic [15:0] iz);
    tx_buf[0] = {1'b1, inc, a};
    for (int i = 1; i < 8; i++) tx_buf[i] = 8'h00;
    spi_xfer(n + 1, 0, inj_after, ix, iy, iz);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog expired: compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [5:0] ra;
    rst = 1'b1;
    spi.cs_n = 1'b1; spi.sclk = 1'b1; spi.mosi = 1'b0;
    sample_valid = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
    model_reset();
    wait_clk(6);
    check("rst_miso", {15'd0, spi.miso}, 16'd0);
    check("rst_miso_oe", {15'd0, spi.miso_oe}, 16'd0);
    check("rst_irq", {15'd0, interrupt}, 16'd0);
    check("rst_ctrl1", {8'd0, ctrl_reg1}, 16'd0);
    check("rst_ctrl4", {8'd0, ctrl_reg4}, 16'd0);
    rst = 1'b0;
    wait_clk(4);

    wr(6'h20, 8'h4F);
    wr(6'h22, 8'h08);
    wr(6'h23, 8'h10);
    rd_burst(6'h0F, 1'b0, 1, -1, 16'h0, 16'h0, 16'h0);

    pulse_sample(16'h1234, 16'hFEDC, 16'h0A0B);
    check("irq_after_sample", {15'd0, interrupt}, 16'd1);
    rd_burst(6'h28, 1'b1, 6, -1, 16'h0, 16'h0, 16'h0);

    pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
    rd_burst(6'h28, 1'b1, 6, 2, 16'h5555, 16'($urandom), 16'($urandom));
    rd_burst(6'h28, 1'b1, 6, -1, 16'h0, 16'h0, 16'h0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1)
        pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
      case ($urandom_range(0, 5))
        0: ra = 6'h20;
        1: ra = 6'h21;
        2: ra = 6'h22;
        3: ra = 6'h23;
        4: ra = 6'h0F;
        default: ra = 6'h28;
      endcase
      tx_buf[0] = {1'b0, 1'($urandom_range(0, 1)), ra};
      tx_buf[1] = 8'($urandom);
      tx_buf[2] = 8'($urandom);
      spi_xfer(3, 0, -1, 16'h0, 16'h0, 16'h0);
      rd_burst(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 4)), -1, 16'h0, 16'h0, 16'h0);
    end

    wr(6'h22, 8'h08);
    wr(6'h20, 8'h00);
    rd_burst(6'h28, 1'b1, 6, -1, 16'h0, 16'h0, 16'h0);
    pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
    check("irq_powered_down", {15'd0, interrupt}, 16'd0);
    rd_burst(6'h28, 1'b1, 6, -1, 16'h0, 16'h0, 16'h0);

    tx_buf[0] = 8'h20;
    tx_buf[1] = 8'h4F;
    spi_xfer(2, 4, -1, 16'h0, 16'h0, 16'h0);
    tx_buf[0] = 8'h7F;
    tx_buf[1] = 8'hAA;
    tx_buf[2] = 8'hBB;
    spi_xfer(3, 0, -1, 16'h0, 16'h0, 16'h0);

    wr(6'h20, 8'h4F);
    pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
    check("irq_before_rst", {15'd0, interrupt}, 16'd1);
    spi.cs_n = 1'b0;
    wait_clk(HALF);
    send_bits(8'h8F, 8, got);
    send_bits(8'h00, 3, got);
    rst = 1'b1;
    wait_clk(1);
    model_reset();
    check("midrst_miso", {15'd0, spi.miso}, 16'd0);
    check("midrst_miso_oe", {15'd0, spi.miso_oe}, 16'd0);
    check("midrst_irq", {15'd0, interrupt}, 16'd0);
    check("midrst_ctrl1", {8'd0, ctrl_reg1}, 16'd0);
    check("midrst_ctrl3", {8'd0, ctrl_reg3}, 16'd0);
    check("midrst_ctrl4", {8'd0, ctrl_reg4}, 16'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    send_bits(8'h20, 8, got);
    send_bits(8'hFF, 8, got);
    wait_clk(HALF);
    spi.cs_n = 1'b1;
    wait_clk(8);
    check("unarmed_ctrl1", {8'd0, ctrl_reg1}, 16'd0);
    wr(6'h20, 8'h4F);
    rd_burst(6'h28, 1'b1, 2, -1, 16'h0, 16'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_accel_slave.md
Name: spi_accel_slave

Overview:
- SPI mode-3 responder that emulates the 3-axis sensor's register map, at the far end of the byte-level SPI controller that configures the sensor and reads X/Y/Z.
- Decodes address bytes, accepts register writes, serves single and auto-increment reads of X/Y/Z, and raises a data-ready interrupt.
- Sits behind the SPI pins in the hardware-in-the-loop build and in the system testbench; axis samples are fed from a stimulus or sensor source.

Parameters:
- WHO_AM_I_VAL, 8'hD3, read-only value at address 0x0F
- SYNC_STAGES, 2, synchroniser depth for sclk, mosi and cs_n (minimum 2)

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency
- rst  input  1  synchronous reset, active-high
- sclk  input  1  SPI clock, idles high
- cs_n  input  1  chip select, active low
- mosi  input  1  master-out data
- miso  output  1  slave-out data, valid while miso_oe=1
- miso_oe  output  1  output enable; 1 whenever synchronised cs_n=0
- sample_valid  input  1  one-cycle strobe; x_in, y_in, z_in are valid
- x_in / y_in / z_in  input  16 each  signed axis samples
- interrupt  output  1  data-ready, level
- ctrl_reg1 / ctrl_reg3 / ctrl_reg4  output  8 each  contents of registers 0x20, 0x22, 0x23

Behaviour:
- Clocking: single clk domain. sclk, mosi and cs_n pass through SYNC_STAGES flops. sclk rise and fall are detected from the synchronised copy. All actions below happen in the cycle after detection.
- Reset values: miso=0, miso_oe=0, interrupt=0, all ctrl regs 8'h00, live and shadow X/Y/Z=0, state=IDLE, bit_cnt=0.
- rst overrides everything, including an open transaction. After reset, the block ignores the transfer until cs_n has been seen high.
- Register map:
  - 0x0F WHO_AM_I, read-only
  - 0x20, 0x22, 0x23, read/write
  - 0x27 STATUS, read-only; bit3 = ZYXDA (new data pending)
  - 0x28..0x2D OUT_X_L, X_H, Y_L, Y_H, Z_L, Z_H, read-only
  - All other addresses read 8'h00; writes to them, and to read-only addresses, are ignored.
- Address byte: bit7=1 read / 0 write; bit6=1 auto-increment; bits5:0 = register address.
- Bit timing:
  - mosi is sampled on the sclk rising edge, MSB first. bit_cnt counts rising edges 0..7 and wraps to 0 at each byte boundary.
  - miso always presents tx_sreg[7]. On an sclk falling edge, tx_sreg shifts left only if bit_cnt != 0.
  - miso=0 during the address byte and write bytes.
- State machine:
  - IDLE: cs_n falling edge -> ADDR. bit_cnt=0. Shadow X/Y/Z and STATUS are copied from live registers in the same cycle.
  - ADDR: on the 8th rising edge, latch rw, inc and addr. If read, load tx_sreg with the shadow-map byte at addr -> READ. Otherwise -> WRITE.
  - WRITE: each completed byte is written to addr. If inc=1, addr increments. Stays in WRITE.
  - READ: each completed byte boundary with inc=1 increments addr and loads the byte at the new addr. With inc=0, the same addr is reloaded.
  - Any state: cs_n rising edge -> IDLE. A partial byte is discarded with no write and no side effects.
- Address wrap: increment is 6-bit modulo (0x3F -> 0x00).
- Sample capture:
  - sample_valid with ctrl_reg1[3]=1 (power-up) loads live X/Y/Z and sets ZYXDA.
  - With ctrl_reg1[3]=0, samples are dropped.
  - A sample arriving mid-transaction updates only the live copy; the bytes being read stay coherent from the shadow.
- interrupt = ZYXDA & ctrl_reg3[3].
  - ZYXDA clears when a byte from address 0x2D finishes loading into tx_sreg for a read.
  - If sample_valid occurs in the same cycle as that clear, the set wins.
- Byte 0x2D is loaded as the last byte; reading further past 0x2D returns 0x00 (0x2E, 0x2F) and then continues per the map.

Test Plan:
- Reset, then write 0x20/0x4F, 0x22/0x08, 0x23/0x10 in three transactions -> ctrl_reg1=0x4F, ctrl_reg3=0x08, ctrl_reg4=0x10; interrupt=0.
- Read 0x8F -> miso returns 0xD3 MSB-first; miso=0 throughout the address byte; miso_oe tracks cs_n.
- ctrl_reg1=0x4F; sample_valid with x=0x1234, y=0xFEDC, z=0x0A0B -> interrupt=1 next cycle. Address 0xE8 plus 6 bytes -> 34 12 DC FE 0B 0A; interrupt=0 after the 6th byte loads.
- During that 6-byte read, pulse sample_valid with x=0x5555 after byte 2 -> read still returns the original bytes; interrupt=1 after cs_n rises. A second read returns 55 55 …
- ctrl_reg1=0x00; sample_valid -> live data unchanged, interrupt stays 0.
- Deassert cs_n after 4 bits of a write data byte to 0x20 -> ctrl_reg1 unchanged. Then address 0x7F with auto-increment write of 0xAA, 0xBB -> wraps to 0x00; no ctrl reg changes. Assert rst mid-read -> all outputs at reset values the next cycle.
